// File: rtl/ws2812b_pkg.sv
// Shared types and helpers for the WS2812B frame generator.
// Colours are carried in GRB order, matching what the serial driver shifts out.
package ws2812b_pkg;

  typedef logic [23:0] grb_t;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_RAINBOW = 2'd2,
    MODE_CHASE   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StWaitTick = 2'd0,
    StRender   = 2'd1,
    StCommit   = 2'd2,
    StHold     = 2'd3
  } state_e;

  function automatic grb_t pack_grb(input logic [7:0] r, input logic [7:0] g,
                                    input logic [7:0] b);
    return {g, r, b};
  endfunction

  function automatic logic [7:0] grb_r(input grb_t c);
    return c[15:8];
  endfunction

  function automatic logic [7:0] grb_g(input grb_t c);
    return c[23:16];
  endfunction

  function automatic logic [7:0] grb_b(input grb_t c);
    return c[7:0];
  endfunction

endpackage

// File: rtl/color_wheel.sv
// Combinational colour wheel: 8-bit hue to a fully saturated GRB colour.
// Three linear segments of 85 hue steps each, ramping one channel up and the previous one down.
module color_wheel
  import ws2812b_pkg::*;
(
  input  logic [7:0] i_hue,
  output grb_t       o_grb
);

  logic [7:0] w_off;
  logic [9:0] w_prod;
  logic [7:0] w_up;
  logic [7:0] w_dn;

  always_comb begin
    w_off = i_hue;
    if (i_hue >= 8'd170) begin
      w_off = i_hue - 8'd170;
    end else if (i_hue >= 8'd85) begin
      w_off = i_hue - 8'd85;
    end
  end

  // w_off never exceeds 85, so 3*w_off fits in 8 bits
  assign w_prod = 10'(w_off) * 10'd3;
  assign w_up   = w_prod[7:0];
  assign w_dn   = 8'd255 - w_up;

  always_comb begin
    o_grb = '0;
    if (i_hue < 8'd85) begin
      o_grb = pack_grb(w_dn, w_up, 8'd0);
    end else if (i_hue < 8'd170) begin
      o_grb = pack_grb(8'd0, w_dn, w_up);
    end else begin
      o_grb = pack_grb(w_up, 8'd0, w_dn);
    end
  end

endmodule

// File: rtl/ws2812b_frame_gen.sv
// Renders one GRB word per LED into a shadow buffer on each frame tick, then hands the frame
// to the WS2812B driver with a single start strobe once the driver is idle.
module ws2812b_frame_gen
  import ws2812b_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = 7,
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned FRAME_HZ   = 60,
  parameter int unsigned HUE_STEP   = 2,
  parameter int unsigned HUE_SPREAD = 256 / NUM_LEDS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
  input  logic [23:0]           i_color,
  input  logic [7:0]            i_brightness,
  input  logic                  i_is_refreshing,
  output logic [NUM_LEDS*24-1:0] o_data,
  output logic                  o_start_refresh,
  output logic                  o_frame_drop
);

  localparam int unsigned FRAME_DIV = CLK_FREQ / FRAME_HZ;
  localparam int unsigned CNT_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned IDX_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_tick_cnt;
  logic                  r_pending;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_chase_pos;
  logic [7:0]            r_base_hue;
  mode_e                 r_mode;
  grb_t                  r_color;
  logic [7:0]            r_bright;
  logic [NUM_LEDS*24-1:0] r_shadow;
  logic [NUM_LEDS*24-1:0] r_data;
  logic                  r_start_refresh;
  logic                  r_frame_drop;

  logic                  w_tick;
  logic                  w_latch;
  logic                  w_commit;
  logic                  w_last_idx;
  logic                  w_busy;
  logic [7:0]            w_hue;
  grb_t                  w_wheel;
  grb_t                  w_raw;
  grb_t                  w_led;

  assign w_tick     = (r_tick_cnt == '0);
  assign w_last_idx = (r_idx == IDX_W'(NUM_LEDS - 1));
  assign w_busy     = (r_state != StWaitTick);
  assign w_hue      = r_base_hue + 8'(32'(r_idx) * HUE_SPREAD);

  color_wheel u_color_wheel (
    .i_hue (w_hue),
    .o_grb (w_wheel)
  );

  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction

  always_comb begin
    w_raw = '0;
    unique case (r_mode)
      MODE_OFF:     w_raw = '0;
      MODE_SOLID:   w_raw = r_color;
      MODE_RAINBOW: w_raw = w_wheel;
      MODE_CHASE:   w_raw = (r_idx == r_chase_pos) ? r_color : '0;
      default:      w_raw = '0;
    endcase
    w_led = pack_grb(scale8(grb_r(w_raw), r_bright), scale8(grb_g(w_raw), r_bright),
                     scale8(grb_b(w_raw), r_bright));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      StWaitTick: begin
        if ((w_tick || r_pending) && i_enable) begin
          w_latch     = 1'b1;
          w_state_nxt = StRender;
        end
      end
      StRender: begin
        if (w_last_idx) w_state_nxt = StCommit;
      end
      StCommit: begin
        if (!i_is_refreshing) begin
          w_commit    = 1'b1;
          w_state_nxt = StHold;
        end
      end
      StHold:   w_state_nxt = StWaitTick;
      default:  w_state_nxt = StWaitTick;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= StWaitTick;
      r_tick_cnt      <= CNT_W'(FRAME_DIV - 1);
      r_pending       <= 1'b0;
      r_idx           <= '0;
      r_chase_pos     <= '0;
      r_base_hue      <= 8'd0;
      r_mode          <= MODE_OFF;
      r_color         <= '0;
      r_bright        <= 8'd0;
      r_data          <= '0;
      r_start_refresh <= 1'b0;
      r_frame_drop    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_tick_cnt      <= w_tick ? CNT_W'(FRAME_DIV - 1) : r_tick_cnt - 1'b1;
      r_start_refresh <= w_commit;
      // One tick may queue behind a frame in flight; a second one is dropped
      r_frame_drop    <= w_tick && w_busy && r_pending;
      if (w_latch) begin
        r_pending <= 1'b0;
      end else if (w_tick && w_busy) begin
        r_pending <= 1'b1;
      end
      if (w_latch) begin
        r_mode   <= mode_e'(i_mode);
        r_color  <= i_color;
        r_bright <= i_brightness;
        r_idx    <= '0;
      end else if (r_state == StRender && !w_last_idx) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_commit) begin
        r_data <= r_shadow;
        if (r_mode == MODE_RAINBOW) r_base_hue <= r_base_hue + 8'(HUE_STEP);
        if (r_mode == MODE_CHASE) begin
          r_chase_pos <= (r_chase_pos == IDX_W'(NUM_LEDS - 1)) ? '0 : r_chase_pos + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_state == StRender) begin
      r_shadow[32'(r_idx) * 24 +: 24] <= w_led;
    end
  end

  assign o_data          = r_data;
  assign o_start_refresh = r_start_refresh;
  assign o_frame_drop    = r_frame_drop;

endmodule

// File: tb/tb_ws2812b_frame_gen.sv
// Directed bench for ws2812b_frame_gen: solid, brightness, rainbow, chase, backpressure, reset.
// Cycle 0 is the first cycle with reset low; outputs are sampled 1 time unit after each edge.
module tb_ws2812b_frame_gen;

  localparam int unsigned NumLeds = 7;
  localparam int unsigned DW      = NumLeds * 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic [23:0]   color;
  logic [7:0]    bright;
  logic          refreshing;
  logic [DW-1:0] data;
  logic          start_refresh;
  logic          frame_drop;

  int cyc     = 0;
  int base    = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ws2812b_frame_gen #(
    .NUM_LEDS   (NumLeds),
    .CLK_FREQ   (1000),
    .FRAME_HZ   (10),
    .HUE_STEP   (4),
    .HUE_SPREAD (36)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_mode          (mode),
    .i_color         (color),
    .i_brightness    (bright),
    .i_is_refreshing (refreshing),
    .o_data          (data),
    .o_start_refresh (start_refresh),
    .o_frame_drop    (frame_drop)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic goto(input int n);
    while (cyc - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [23:0] led(input int k);
    return data[k*24 +: 24];
  endfunction

  logic [DW-1:0] exp_v;
  int            n_strobes;

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    mode       = 2'd1;
    color      = 24'h102030;
    bright     = 8'd255;
    refreshing = 1'b0;

    // Solid colour, full brightness
    do_reset(3);
    check("rst_data", data, '0);
    check("rst_strobe", DW'(start_refresh), '0);
    check("rst_drop", DW'(frame_drop), '0);
    goto(107);
    check("solid_pre_strobe", DW'(start_refresh), '0);
    check("solid_pre_data", data, '0);
    goto(108);
    check("solid_strobe", DW'(start_refresh), DW'(1));
    check("solid_data", data, {NumLeds{24'h102030}});
    goto(109);
    check("solid_strobe_width", DW'(start_refresh), '0);
    goto(207);
    check("solid_gap", DW'(start_refresh), '0);
    goto(208);
    check("solid_strobe2", DW'(start_refresh), DW'(1));

    // Brightness scaling
    color  = 24'hFF8000;
    bright = 8'd128;
    do_reset(2);
    goto(108);
    check("bright128_led0", DW'(led(0)), DW'(24'h804000));
    check("bright128_led6", DW'(led(6)), DW'(24'h804000));
    goto(110);
    bright = 8'd0;
    goto(208);
    check("bright0_strobe", DW'(start_refresh), DW'(1));
    check("bright0_data", data, '0);

    // Rainbow
    mode   = 2'd2;
    bright = 8'd255;
    do_reset(2);
    goto(108);
    check("rainbow_f0_led0", DW'(led(0)), DW'(24'h00FF00));
    check("rainbow_f0_led1", DW'(led(1)), DW'(24'h6C9300));
    check("rainbow_f0_led2", DW'(led(2)), DW'(24'hD82700));
    check("rainbow_f0_led3", DW'(led(3)), DW'(24'hBA0045));
    check("rainbow_f0_led5", DW'(led(5)), DW'(24'h001EE1));
    goto(208);
    check("rainbow_f1_led0", DW'(led(0)), DW'(24'h0CF300));

    // Reset in the middle of rendering frame 2
    goto(302);
    check("midrst_pre_led0", DW'(led(0)), DW'(24'h0CF300));
    do_reset(1);
    check("midrst_data", data, '0);
    check("midrst_strobe", DW'(start_refresh), '0);
    n_strobes = 0;
    for (int n = 1; n < 108; n++) begin
      goto(n);
      if (start_refresh) n_strobes++;
    end
    check("midrst_no_early_strobe", DW'(n_strobes), '0);
    goto(108);
    check("midrst_strobe_after", DW'(start_refresh), DW'(1));
    check("midrst_hue_restart", DW'(led(1)), DW'(24'h6C9300));

    // Chase
    mode  = 2'd3;
    color = 24'h00FF00;
    do_reset(2);
    for (int f = 0; f < 8; f++) begin
      goto(108 + 100 * f);
      check($sformatf("chase_strobe_f%0d", f), DW'(start_refresh), DW'(1));
      exp_v = '0;
      exp_v[(f % NumLeds) * 24 +: 24] = 24'h00FF00;
      check($sformatf("chase_data_f%0d", f), data, exp_v);
    end

    // Backpressure: driver busy over cycles 100..349
    mode  = 2'd1;
    color = 24'h112233;
    do_reset(2);
    goto(100);
    refreshing = 1'b1;
    goto(200);
    check("bp_pending_no_drop", DW'(frame_drop), '0);
    check("bp_data_held", data, '0);
    goto(299);
    check("bp_drop_pre", DW'(frame_drop), '0);
    goto(300);
    check("bp_drop", DW'(frame_drop), DW'(1));
    goto(301);
    check("bp_drop_width", DW'(frame_drop), '0);
    goto(350);
    refreshing = 1'b0;
    check("bp_strobe_pre", DW'(start_refresh), '0);
    goto(351);
    check("bp_strobe", DW'(start_refresh), DW'(1));
    check("bp_data", data, {NumLeds{24'h112233}});
    goto(360);
    check("bp_rerender_pre", DW'(start_refresh), '0);
    goto(361);
    check("bp_rerender_strobe", DW'(start_refresh), DW'(1));
    goto(408);
    check("bp_next_tick_strobe", DW'(start_refresh), DW'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812b_frame_gen.md
# ws2812b_frame_gen

Frame generator that sits directly upstream of the WS2812B serial driver: it renders one GRB word per LED into a shadow buffer at a fixed frame rate, then hands the full frame to the driver with a one-cycle `start_refresh` strobe once the driver is idle. It provides solid, rainbow and chase animations with global brightness scaling, so top level only selects the mode and colour.

## Interface
- `NUM_LEDS`, 7: number of LEDs in the chain; must match the driver.
- `CLK_FREQ`, 25000000: clock frequency in Hz.
- `FRAME_HZ`, 60: frame rate. `FRAME_DIV = CLK_FREQ / FRAME_HZ` (integer division).
- `HUE_STEP`, 2: hue advance per committed frame in rainbow mode (8-bit, wraps).
- `HUE_SPREAD`, 256/NUM_LEDS: hue offset between adjacent LEDs (integer division).
- `i_clk`  in  1: the block's single clock.
- `i_rst`  in  1: reset, synchronous and active-high.
- `i_enable`  in  1: when low, frame ticks are ignored and animation state is frozen.
- `i_mode`  in  2: 0 off, 1 solid, 2 rainbow, 3 chase.
- `i_color`  in  24: GRB colour for solid and chase modes.
- `i_brightness`  in  8: global brightness.
- `i_is_refreshing`  in  1: driver busy flag.
- `o_data`  out  NUM_LEDS*24: frame to the driver; LED k is at bits [24k +: 24], GRB order.
- `o_start_refresh`  out  1: one-cycle strobe to the driver.
- `o_frame_drop`  out  1: one-cycle pulse when a frame tick is discarded.

## Operation
- Reset values: `o_data` = 0, `o_start_refresh` = 0, `o_frame_drop` = 0, base_hue = 0, chase_pos = 0, pending = 0, tick counter = FRAME_DIV-1, state WAIT_TICK.
- Tick counter counts down every cycle. It reloads FRAME_DIV-1 after reaching 0, and `tick` is asserted on the cycle it is 0. The counter runs regardless of state.
- States:
  - WAIT_TICK: if (`tick` or pending) and `i_enable`, latch `i_mode`, `i_color` and `i_brightness` for the whole frame, clear pending, set idx = 0 and go to RENDER.
  - RENDER: each cycle, write shadow[idx] = scale(colour(idx)). Go to COMMIT when idx == NUM_LEDS-1; otherwise increment idx.
  - COMMIT: wait while `i_is_refreshing` is high. When it is low, register `o_data` <= shadow and `o_start_refresh` <= 1. Advance base_hue += HUE_STEP (mode 2 only) or chase_pos (mode 3 only; wraps NUM_LEDS-1 → 0), then go to HOLD.
  - HOLD: one cycle, then return to WAIT_TICK.
- Tick outside WAIT_TICK:
  - if pending = 0, set pending = 1;
  - if pending is already set, pulse `o_frame_drop`.
- Tick in WAIT_TICK with `i_enable` low is ignored, with no drop pulse.
- Colour per LED k:
  - mode 0: 0x000000.
  - mode 1: latched colour.
  - mode 2: wheel(h), where h = base_hue + k*HUE_SPREAD mod 256.
  - mode 3: latched colour if k == chase_pos, else 0.
- Wheel (R, G, B), with h' = h − segment start:
  - h < 85: (255−3h, 3h, 0).
  - 85 ≤ h < 170: (0, 255−3h', 3h').
  - h ≥ 170: (3h', 0, 255−3h').
  - Pack as {G, R, B}.
- Scaling, per 8-bit channel: out = (c * (b+1)) >> 8, using a 16-bit intermediate and keeping the low 8 bits. b = 255 passes the colour through; b = 0 gives 0.
- `o_data` changes only on the COMMIT-exit cycle and is stable otherwise.
- `i_rst` mid-frame: return to reset values on the next edge; the shadow contents are don't-care. A driver refresh already in progress is unaffected.

## Timing
- First tick occurs FRAME_DIV-1 cycles after the first cycle with `i_rst` low.
- With the tick at cycle T and the driver idle:
  - RENDER occupies T+1 … T+NUM_LEDS;
  - COMMIT is at T+NUM_LEDS+1;
  - `o_start_refresh` and the new `o_data` are visible at T+NUM_LEDS+2.
- Backpressure: if `i_is_refreshing` first reads low in COMMIT at cycle C, the strobe appears at C+1.
- Strobe width is exactly 1 cycle. At most one strobe per frame.
- Inputs are sampled only at WAIT_TICK exit; changes during RENDER affect the next frame only.

## Structure
- Package `ws2812b_pkg`:
  - mode enum (`MODE_OFF`, `MODE_SOLID`, `MODE_RAINBOW`, `MODE_CHASE`);
  - state enum;
  - GRB pack/unpack functions;
  - 24-bit colour typedef.
- Sub-module `color_wheel`: combinational, 8-bit hue → 24-bit GRB, instantiated once.
- Scaling logic stays inline.

## Test plan
- Common parameters: NUM_LEDS = 7, CLK_FREQ = 1000, FRAME_HZ = 10 (FRAME_DIV = 100).
- Solid: mode 1, colour 0x102030, brightness 255, driver idle → strobe at cycle 108; `o_data` = 7× 0x102030; the next strobe follows 100 cycles later.
- Brightness: mode 1, colour 0xFF8000, brightness 128 → each LED = 0x804000; brightness 0 → all zero, and the strobe still occurs.
- Rainbow (HUE_STEP = 4, HUE_SPREAD = 36):
  - frame 0: LED0 = 0x00FF00, LED1 = 0x6C9300;
  - frame 1: LED0 = 0x0CF300.
- Chase: colour 0x00FF00 → lit LED index over frames 0..7 is 0, 1, 2, 3, 4, 5, 6, 0; all other LEDs are 0.
- Backpressure: hold `i_is_refreshing` high for 250 cycles across COMMIT →
  - the strobe comes exactly 1 cycle after it falls;
  - the first extra tick sets pending and causes an immediate re-render after HOLD;
  - the second extra tick produces a one-cycle `o_frame_drop`.
- Reset mid-RENDER → on the next cycle all outputs are 0; no strobe occurs until a full FRAME_DIV has elapsed; base_hue restarts at 0.
